// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mul_pkg;

   localparam int MUL_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FIXUP,
      DONE
   } mul_state_e;

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier.
interface seq_multiplier_if
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic             signed_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             carry_out;

   modport master (
      output in_valid, op1, op2, signed_mode, out_ready,
      input  in_ready, out_valid, result, result_hi, carry_out
   );

   modport slave (
      input  in_valid, op1, op2, signed_mode, out_ready,
      output in_ready, out_valid, result, result_hi, carry_out
   );

endinterface

// File: rtl/seq_multiplier.sv
// Sequential multiplier: one shift-add step per cycle on magnitudes, sign fixed up at the end.
module seq_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input logic              clk,
   input logic              rst,
   seq_multiplier_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam int PROD_W = 2 * WIDTH;

   mul_state_e        state;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH-1:0]  mcand;
   logic [PROD_W-1:0] acc;
   logic              neg;
   logic              smode;
   logic              in_ready_r;
   logic              out_valid_r;
   logic [WIDTH-1:0]  result_r;
   logic [WIDTH-1:0]  result_hi_r;
   logic              carry_r;
   logic [PROD_W-1:0] prod_fix;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] op, input logic sm);
      logic signed [WIDTH-1:0] s_op;
      s_op = signed'(op);
      if (sm && s_op < 0)
         return unsigned'(-s_op);
      return op;
   endfunction

   // Add the multiplicand into the upper half when the current multiplier bit is set, then shift right.
   function automatic logic [PROD_W-1:0] shift_add(input logic [PROD_W-1:0] a, input logic [WIDTH-1:0] m);
      logic [WIDTH:0] sum;
      sum = {1'b0, a[PROD_W-1:WIDTH]} + (a[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      return {sum, a[WIDTH-1:1]};
   endfunction

   function automatic logic overflow(input logic [PROD_W-1:0] p, input logic sm);
      if (sm)
         return p[PROD_W-1:WIDTH] != {WIDTH{p[WIDTH-1]}};
      return p[PROD_W-1:WIDTH] != '0;
   endfunction

   always_comb begin
      prod_fix = acc;
      if (neg)
         prod_fix = -acc;
   end

   // Datapath registers carry no reset; they are always reloaded at acceptance before use.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (bus.in_valid && in_ready_r) begin
               mcand <= magnitude(bus.op1, bus.signed_mode);
               acc   <= {{WIDTH{1'b0}}, magnitude(bus.op2, bus.signed_mode)};
               neg   <= bus.signed_mode & (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
               smode <= bus.signed_mode;
            end
         end
         BUSY: acc <= shift_add(acc, mcand);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         result_r    <= '0;
         result_hi_r <= '0;
         carry_r     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  cnt        <= CNT_W'(WIDTH - 1);
                  in_ready_r <= 1'b0;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == '0)
                  state <= FIXUP;
            end
            FIXUP: begin
               result_r    <= prod_fix[WIDTH-1:0];
               result_hi_r <= prod_fix[PROD_W-1:WIDTH];
               carry_r     <= overflow(prod_fix, smode);
               out_valid_r <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.result_hi = result_hi_r;
   assign bus.carry_out = carry_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed-vector bench for seq_multiplier at WIDTH=16.
module tb_seq_multiplier;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   seq_multiplier_if #(.WIDTH(16)) bus ();

   seq_multiplier #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic sm,
                         input logic [15:0] elo, input logic [15:0] ehi, input logic ec);
      int n;
      bus.op1         = a;
      bus.op2         = b;
      bus.signed_mode = sm;
      bus.out_ready   = 1'b1;
      bus.in_valid    = 1'b1;
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid    = 1'b0;
      bus.op1         = ~a;
      bus.op2         = b + 16'd1;
      bus.signed_mode = ~sm;
      chk({tag, "_busy_ready"}, 64'(bus.in_ready), 64'd0);
      n = 0;
      while (!bus.out_valid && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, 64'(n), 64'd17);
      chk({tag, "_lo"}, 64'(bus.result), 64'(elo));
      chk({tag, "_hi"}, 64'(bus.result_hi), 64'(ehi));
      chk({tag, "_carry"}, 64'(bus.carry_out), 64'(ec));
      tick();
      chk({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_ready_back"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      int n;
      logic seen;
      total = 0;
      bad   = 0;
      rst             = 1'b1;
      bus.in_valid    = 1'b0;
      bus.op1         = '0;
      bus.op2         = '0;
      bus.signed_mode = 1'b0;
      bus.out_ready   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_lo", 64'(bus.result), 64'd0);
      chk("rst_hi", 64'(bus.result_hi), 64'd0);
      chk("rst_carry", 64'(bus.carry_out), 64'd0);
      chk("rst_ready", 64'(bus.in_ready), 64'd1);

      run_op("u3x5",      16'h0003, 16'h0005, 1'b0, 16'h000F, 16'h0000, 1'b0);
      run_op("uffxff",    16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 1'b1);
      run_op("sm3x5",     16'hFFFD, 16'h0005, 1'b1, 16'hFFF1, 16'hFFFF, 1'b0);
      run_op("s8000sq",   16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h4000, 1'b1);
      run_op("u0xffff",   16'h0000, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 1'b0);
      run_op("s7fffsq",   16'h7FFF, 16'h7FFF, 1'b1, 16'h0001, 16'h3FFF, 1'b1);
      run_op("sm1xm1",    16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 16'h0000, 1'b0);
      run_op("u100sq",    16'h0100, 16'h0100, 1'b0, 16'h0000, 16'h0001, 1'b1);
      run_op("s8000x1",   16'h8000, 16'h0001, 1'b1, 16'h8000, 16'hFFFF, 1'b0);
      run_op("sm1x1",     16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);

      // Backpressure: result must hold while the consumer stalls.
      bus.out_ready   = 1'b0;
      bus.op1         = 16'h1234;
      bus.op2         = 16'h0010;
      bus.signed_mode = 1'b0;
      bus.in_valid    = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 40) begin
         tick();
         n++;
      end
      chk("bp_latency", 64'(n), 64'd17);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = i[0];
         bus.op1      = 16'h0002 + 16'(i);
         bus.op2      = 16'h0003;
         tick();
         chk("bp_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_lo", 64'(bus.result), 64'h2340);
         chk("bp_hi", 64'(bus.result_hi), 64'h0001);
         chk("bp_carry", 64'(bus.carry_out), 64'd1);
         chk("bp_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
      chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
      tick();
      chk("bp_idle_ready", 64'(bus.in_ready), 64'd1);

      // Reset mid-operation must abort without ever presenting a result.
      bus.op1         = 16'h0003;
      bus.op2         = 16'h0005;
      bus.signed_mode = 1'b0;
      bus.in_valid    = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_lo", 64'(bus.result), 64'd0);
      chk("abort_hi", 64'(bus.result_hi), 64'd0);
      chk("abort_carry", 64'(bus.carry_out), 64'd0);
      chk("abort_ready", 64'(bus.in_ready), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (bus.out_valid) seen = 1'b1;
      end
      chk("abort_no_result", 64'(seen), 64'd0);
      run_op("u2x7", 16'h0002, 16'h0007, 1'b0, 16'h000E, 16'h0000, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and result-half width in bits (legal range 2..64).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operands and mode are presented.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-006 SHALL have port op1, input, WIDTH bits: multiplicand.
REQ-007 SHALL have port op2, input, WIDTH bits: multiplier.
REQ-008 SHALL have port signed_mode, input, 1 bit: 1 means two's-complement operands, 0 means unsigned.
REQ-009 SHALL have port out_valid, output, 1 bit: result fields are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port result, output, WIDTH bits: low half of the product.
REQ-012 SHALL have port result_hi, output, WIDTH bits: high half of the product.
REQ-013 SHALL have port carry_out, output, 1 bit: set when the product does not fit in WIDTH bits for the selected mode.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, FIXUP, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; acceptance is the edge where in_valid and in_ready are both 1.
REQ-016 On acceptance SHALL capture op1, op2 and signed_mode, go to BUSY, and load the iteration counter with WIDTH-1.
REQ-017 Operand changes after acceptance SHALL have no effect on the operation in flight.
REQ-018 In signed mode SHALL multiply operand magnitudes and record the result sign as op1[MSB] XOR op2[MSB].
REQ-019 In unsigned mode SHALL use the operands directly, with the recorded sign forced to 0.
REQ-020 In BUSY SHALL perform one shift-add step per cycle on a 2*WIDTH-bit accumulator, decrementing the counter.
REQ-021 SHALL go BUSY to FIXUP on the edge where the counter is 0, giving exactly WIDTH BUSY cycles.
REQ-022 In FIXUP SHALL two's-complement-negate the 2*WIDTH-bit product if the recorded sign is 1, then go to DONE.
REQ-023 out_valid SHALL be 1 only in DONE, first visible after acceptance edge + WIDTH + 1 edges (latency WIDTH+1).
REQ-024 result and result_hi SHALL be the low and high halves of the exact 2*WIDTH-bit product, registered.
REQ-025 carry_out in unsigned mode SHALL be 1 iff result_hi is nonzero.
REQ-026 carry_out in signed mode SHALL be 1 iff {result_hi,result} is not the sign-extension of result.
REQ-027 In DONE with out_ready=0 SHALL hold result, result_hi, carry_out and out_valid stable, with in_ready=0.
REQ-028 In DONE with out_ready=1 SHALL return to IDLE on that edge; the next acceptance is possible one cycle later (no overlap).
REQ-029 out_ready SHALL be ignored outside DONE.
REQ-030 A zero operand SHALL still take the full WIDTH+1 latency (no early termination).

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, counter 0, out_valid=0, result=0, result_hi=0, carry_out=0, and in_ready=1 on the next cycle.
REQ-032 Reset asserted in BUSY, FIXUP or DONE SHALL abort the operation, with no result ever presented.
REQ-033 rst SHALL take priority over a simultaneous acceptance or result handshake.

Structure
REQ-034 A shared package mul_pkg SHALL hold the FSM state enum type and the default WIDTH constant.
REQ-035 The datapath SHALL be single-module with no sub-module; the shift-add step, sign conditioning and counter are inline.
REQ-036 The existing combinational multiplier interface SHALL remain unchanged; this block is a separate instantiable unit.

Verification (WIDTH=16)
REQ-037 Unsigned 3*5, out_ready=1 -> out_valid at acceptance+17 edges; result=0x000F, result_hi=0x0000, carry_out=0; in_ready back to 1 next cycle.
REQ-038 Unsigned 0xFFFF*0xFFFF -> result=0x0001, result_hi=0xFFFE, carry_out=1.
REQ-039 Signed -3*5 (0xFFFD, 0x0005) -> result=0xFFF1, result_hi=0xFFFF, carry_out=0; signed 0x8000*0x8000 -> result=0x0000, result_hi=0x4000, carry_out=1.
REQ-040 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-041 rst pulse 8 cycles after acceptance -> out_valid never rises, all outputs 0, in_ready=1; a fresh 2*7 then yields result=0x000E.
